// File: rtl/decoder_scan.sv
// decoder_scan: registered 2**N-way decoder with two modes.
// In direct mode it decodes the select input. In scan mode it steps through
// every output on its own, holding each one for DWELL enabled cycles and
// pulsing wrap when the index rolls over from the last output back to 0.
// All outputs are registered, so each one follows its inputs by exactly one cycle.
// There is no handshake: y/idx/wrap are valid on every cycle after reset.
module decoder_scan #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e3,
    input  logic              e2n,
    input  logic              e1n,
    input  logic              mode,
    input  logic [N-1:0]      in,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int M  = 2**N;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST    = DW'(DWELL - 1);
    localparam logic [M-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {M{1'b1}} : {M{1'b0}};

    // One-hot select for output k, driven with the configured polarity.
    function automatic logic [M-1:0] decode(input logic [N-1:0] k);
        logic [M-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    logic [M-1:0]  y_q, y_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          wrap_q, wrap_d;
    logic          mode_q, mode_d;
    logic          en;
    logic [N-1:0]  idx_inc;

    assign en      = e3 & ~e2n & ~e1n;
    assign idx_inc = idx_q + N'(1);

    // Next-state: a scan entry edge wins, then a disable, then direct decode, then scan stepping.
    always_comb begin
        y_d     = INACTIVE;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        mode_d  = mode;
        if (mode && !mode_q) begin
            // Entering scan always restarts at index 0, even while disabled.
            idx_d   = '0;
            dwell_d = '0;
            if (en) begin
                y_d = decode('0);
            end
        end else if (!en) begin
            // Disabled: outputs inactive, scan position frozen for later resume.
            y_d = INACTIVE;
        end else if (!mode) begin
            y_d = decode(in);
        end else if (dwell_q != DLAST) begin
            dwell_d = dwell_q + DW'(1);
            y_d     = decode(idx_q);
        end else begin
            // Last dwell cycle of this index: advance and flag a rollover.
            dwell_d = '0;
            idx_d   = idx_inc;
            y_d     = decode(idx_inc);
            wrap_d  = (idx_q == {N{1'b1}});
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= INACTIVE;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            mode_q  <= mode_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: three decoder_scan instances share one set of inputs.
//   u_main : N=3, DWELL=4, active-low
//   u_d1   : N=3, DWELL=1, active-low
//   u_al0  : N=2, DWELL=2, active-high (select taken from in[1:0])
// The driver pushes the expected outputs of all three instances for each cycle.
// The monitor pops one entry per cycle and compares it against the outputs.
module tb_decoder_scan;

    typedef struct packed {
        logic [7:0] m_y;
        logic [2:0] m_idx;
        logic       m_wrap;
        logic [7:0] d_y;
        logic [2:0] d_idx;
        logic       d_wrap;
        logic [3:0] a_y;
        logic [1:0] a_idx;
        logic       a_wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       e3 = 1'b1;
    logic       e2n = 1'b0;
    logic       e1n = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] in_s = 3'd0;

    logic [7:0] y_m, y_d;
    logic [2:0] idx_m, idx_d;
    logic       wrap_m, wrap_d;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       wrap_a;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    decoder_scan #(.N(3), .DWELL(4), .ACTIVE_LOW(1)) u_main (
        .clk(clk), .reset(reset), .e3(e3), .e2n(e2n), .e1n(e1n), .mode(mode),
        .in(in_s), .y(y_m), .idx(idx_m), .wrap(wrap_m)
    );

    decoder_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) u_d1 (
        .clk(clk), .reset(reset), .e3(e3), .e2n(e2n), .e1n(e1n), .mode(mode),
        .in(in_s), .y(y_d), .idx(idx_d), .wrap(wrap_d)
    );

    decoder_scan #(.N(2), .DWELL(2), .ACTIVE_LOW(0)) u_al0 (
        .clk(clk), .reset(reset), .e3(e3), .e2n(e2n), .e1n(e1n), .mode(mode),
        .in(in_s[1:0]), .y(y_a), .idx(idx_a), .wrap(wrap_a)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [7:0] lo8(input int k);
        logic [7:0] v;
        v = 8'd1 << k;
        return ~v;
    endfunction

    function automatic exp_t mk(input logic [7:0] my, input int mi, input logic mw,
                                input logic [7:0] dy, input int di, input logic dw,
                                input logic [3:0] ay, input int ai, input logic aw);
        exp_t e;
        e.m_y = my; e.m_idx = 3'(mi); e.m_wrap = mw;
        e.d_y = dy; e.d_idx = 3'(di); e.d_wrap = dw;
        e.a_y = ay; e.a_idx = 2'(ai); e.a_wrap = aw;
        return e;
    endfunction

    // Expected outputs c enabled cycles into a scan (c=0 is the entry edge).
    function automatic exp_t scan_exp(input int c);
        int mi, ai;
        mi = (c / 4) % 8;
        ai = (c / 2) % 4;
        return mk(lo8(mi), mi, (c > 0) && (c % 32 == 0),
                  lo8(c % 8), c % 8, (c > 0) && (c % 8 == 0),
                  4'(1 << ai), ai, (c > 0) && (c % 8 == 0));
    endfunction

    // Drive one cycle of inputs and queue what must appear after the next edge.
    task automatic step(input logic r, input logic v3, input logic v2n, input logic v1n,
                        input logic m, input logic [2:0] i, input exp_t e);
        @(negedge clk);
        reset = r; e3 = v3; e2n = v2n; e1n = v1n; mode = m; in_s = i;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor / scoreboard: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("main_y",    y_m,                  e.m_y);
            chk("main_idx",  {5'd0, idx_m},        {5'd0, e.m_idx});
            chk("main_wrap", {7'd0, wrap_m},       {7'd0, e.m_wrap});
            chk("d1_y",      y_d,                  e.d_y);
            chk("d1_idx",    {5'd0, idx_d},        {5'd0, e.d_idx});
            chk("d1_wrap",   {7'd0, wrap_d},       {7'd0, e.d_wrap});
            chk("al0_y",     {4'd0, y_a},          {4'd0, e.a_y});
            chk("al0_idx",   {6'd0, idx_a},        {6'd0, e.a_idx});
            chk("al0_wrap",  {7'd0, wrap_a},       {7'd0, e.a_wrap});
        end
    end

    // Driver
    initial begin
        exp_t rst_e, off_e;
        rst_e = mk(8'hFF, 0, 0, 8'hFF, 0, 0, 4'h0, 0, 0);

        // Reset state
        step(1, 1, 0, 0, 0, 3'd5, rst_e);
        step(1, 1, 0, 0, 1, 3'd2, rst_e);

        // Direct decode and enable gating
        step(0, 1, 0, 0, 0, 3'd5, mk(8'hDF, 0, 0, 8'hDF, 0, 0, 4'b0010, 0, 0));
        step(0, 1, 0, 0, 0, 3'd3, mk(8'hF7, 0, 0, 8'hF7, 0, 0, 4'b1000, 0, 0));
        step(0, 1, 1, 0, 0, 3'd3, rst_e);
        step(0, 0, 0, 0, 0, 3'd6, rst_e);
        step(0, 1, 0, 1, 0, 3'd6, rst_e);
        step(0, 1, 0, 0, 0, 3'd0, mk(8'hFE, 0, 0, 8'hFE, 0, 0, 4'b0001, 0, 0));
        step(0, 1, 0, 0, 0, 3'd7, mk(8'h7F, 0, 0, 8'h7F, 0, 0, 4'b1000, 0, 0));

        // Scan from entry through a full wrap up to idx 2 with two dwell cycles shown
        for (int c = 0; c < 42; c++) step(0, 1, 0, 0, 1, 3'd0, scan_exp(c));

        // Disable mid-scan for 5 cycles: outputs inactive, positions frozen
        off_e = mk(8'hFF, 2, 0, 8'hFF, 1, 0, 4'h0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1, 1, 3'd0, off_e);

        // Resume without restart, run until main sits at idx 6
        for (int c = 42; c < 58; c++) step(0, 1, 0, 0, 1, 3'd0, scan_exp(c));

        // Mid-scan reset, then release straight into a fresh scan entry
        step(1, 1, 0, 0, 1, 3'd0, rst_e);
        for (int c = 0; c < 6; c++) step(0, 1, 0, 0, 1, 3'd0, scan_exp(c));

        // Scan exit: direct decode resumes, idx keeps its last scan value
        step(0, 1, 0, 0, 0, 3'd4, mk(8'hEF, 1, 0, 8'hEF, 5, 0, 4'b0001, 2, 0));

        // Scan entry while disabled still restarts at 0, then resumes stepping
        step(0, 0, 0, 0, 1, 3'd0, rst_e);
        step(0, 1, 0, 0, 1, 3'd0, mk(8'hFE, 0, 0, 8'hFD, 1, 0, 4'b0001, 0, 0));
        step(0, 1, 0, 0, 1, 3'd0, mk(8'hFE, 0, 0, 8'hFB, 2, 0, 4'b0010, 1, 0));
        step(0, 1, 0, 0, 1, 3'd0, mk(8'hFE, 0, 0, 8'hF7, 3, 0, 4'b0010, 1, 0));
        step(0, 1, 0, 0, 1, 3'd0, mk(8'hFD, 1, 0, 8'hEF, 4, 0, 4'b0100, 2, 0));

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
